// File: rtl/stages_definition_pkg.sv
// Shared types for the hazard controller: per-stage shadow entry and
// operand-forwarding select encoding.
package stages_definition_pkg;

    // Register addresses are zero-extended into a fixed-width slot so the
    // entry type stays parameter-free; REG_AW must not exceed this.
    localparam int REG_AW_MAX = 8;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_MAX-1:0] dst;
        logic                  wr;
        logic                  is_load;
    } stage_t;

    // fwd_sel value 0 reads the register file; value k bypasses from stage k.
    localparam int FWD_RF = 0;

    function automatic int fwd_w(input int nstage);
        return $clog2(nstage + 1);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-to-hazard-controller bundle: decoded instruction fields in,
// stall/flush/forward controls out.
interface pipe_hazard_ctrl_if #(
    parameter int NSTAGE = 3,
    parameter int REG_AW = 4,
    parameter int NSRC   = 2
);
    import stages_definition_pkg::*;
    localparam int FW = fwd_w(NSTAGE);

    logic                             dec_valid;
    logic [NSRC-1:0][REG_AW-1:0]      dec_src;
    logic [NSRC-1:0]                  dec_src_used;
    logic [REG_AW-1:0]                dec_dst;
    logic                             dec_wr;
    logic                             dec_is_load;
    logic                             branch_taken;
    logic                             stall_f;
    logic                             stall_d;
    logic                             flush_d;
    logic                             flush_e;
    logic [NSRC-1:0][FW-1:0]          fwd_sel;

    modport master (
        output dec_valid, dec_src, dec_src_used, dec_dst, dec_wr, dec_is_load, branch_taken,
        input  stall_f, stall_d, flush_d, flush_e, fwd_sel
    );

    modport slave (
        input  dec_valid, dec_src, dec_src_used, dec_dst, dec_wr, dec_is_load, branch_taken,
        output stall_f, stall_d, flush_d, flush_e, fwd_sel
    );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_match.sv
// Per-stage comparator: flags which decode sources hit this stage's
// destination, and which of those hits are pending load results.
module hazard_match
    import stages_definition_pkg::*;
#(
    parameter int NSRC   = 2,
    parameter int REG_AW = 4
) (
    input  stage_t                      entry,
    input  logic [NSRC-1:0][REG_AW-1:0] src,
    input  logic [NSRC-1:0]             src_used,
    output logic [NSRC-1:0]             match,
    output logic [NSRC-1:0]             load_match
);
    always_comb begin
        match      = '0;
        load_match = '0;
        for (int i = 0; i < NSRC; i++) begin
            match[i]      = entry.valid & entry.wr & src_used[i] &
                            (entry.dst == REG_AW_MAX'(src[i]));
            load_match[i] = match[i] & entry.is_load;
        end
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// In-order pipeline hazard controller: load-use stall, branch flush,
// youngest-writer forwarding and saturating event counters.
module pipe_hazard_ctrl
    import stages_definition_pkg::*;
#(
    parameter int NSTAGE   = 3,
    parameter int REG_AW   = 4,
    parameter int NSRC     = 2,
    parameter int LOAD_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         halt,
    input  logic                         cnt_clr,
    pipe_hazard_ctrl_if.slave            bus,
    output logic [NSTAGE-1:0]            stage_valid,
    output logic [$clog2(NSTAGE+1)-1:0]  inflight,
    output logic [CNT_W-1:0]             stall_cnt,
    output logic [CNT_W-1:0]             flush_cnt
);
    localparam int FW = fwd_w(NSTAGE);
    localparam int CW = $clog2(NSTAGE + 1);

    stage_t [NSTAGE-1:0]           stg;
    logic   [NSTAGE-1:0][NSRC-1:0] m;
    logic   [NSTAGE-1:0][NSRC-1:0] lm;
    logic   [NSRC-1:0][FW-1:0]     sel;
    stage_t                        dec_entry;
    logic                          hazard, stall_hz, flush_ev, issue;

    for (genvar g = 0; g < NSTAGE; g++) begin : g_match
        hazard_match #(.NSRC(NSRC), .REG_AW(REG_AW)) u_match (
            .entry      (stg[g]),
            .src        (bus.dec_src),
            .src_used   (bus.dec_src_used),
            .match      (m[g]),
            .load_match (lm[g])
        );
    end

    // Only loads still short of LOAD_LAT are unforwardable.
    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < NSTAGE; k++)
            if (k + 1 < LOAD_LAT) hazard = hazard | (|lm[k]);
        hazard = hazard & bus.dec_valid;
    end

    // Scan oldest to youngest so the youngest eligible writer wins.
    always_comb begin
        sel = '0;
        for (int s = 0; s < NSRC; s++) begin
            sel[s] = FW'(FWD_RF);
            for (int k = NSTAGE - 1; k >= 0; k--)
                if (m[k][s] && (!stg[k].is_load || k + 1 >= LOAD_LAT))
                    sel[s] = FW'(k + 1);
        end
    end

    assign stall_hz    = hazard & ~bus.branch_taken & ~halt;
    assign flush_ev    = bus.branch_taken & ~halt;
    assign issue       = bus.dec_valid & ~hazard & ~bus.branch_taken & ~halt;
    assign bus.stall_f = halt | stall_hz;
    assign bus.stall_d = halt | stall_hz;
    assign bus.flush_d = flush_ev;
    assign bus.flush_e = flush_ev | stall_hz;
    assign bus.fwd_sel = sel;

    always_comb begin
        dec_entry = '0;
        if (issue) begin
            dec_entry.valid   = 1'b1;
            dec_entry.dst     = REG_AW_MAX'(bus.dec_dst);
            dec_entry.wr      = bus.dec_wr;
            dec_entry.is_load = bus.dec_is_load;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stg <= '0;
        end else if (!halt) begin
            stg[0] <= dec_entry;
            for (int k = 1; k < NSTAGE; k++) stg[k] <= stg[k-1];
        end
    end

    // cnt_clr is honoured even while halted; halt only blocks increments.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_hz && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_ev && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        inflight = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            stage_valid[k] = stg[k].valid;
            inflight       = inflight + CW'(stg[k].valid);
        end
    end

endmodule
